// File: rtl/tb_uart.sv
// UART 8N1 receiver with line-length tracking.
// The serial input is synchronized, start bits are checked at mid-bit and
// data/stop bits are sampled at bit centers. Good bytes are committed to
// rx_data with a one-cycle rx_valid pulse. A low stop bit raises frame_err
// and the receiver then waits for the line to return high before it can
// start another frame. line_len counts committed non-newline bytes since the
// last newline (0x0A) and saturates at 63.
module tb_uart #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [5:0] line_len,
  output logic       line_done
);

  localparam logic [15:0] BIT_CNT  = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);
  localparam logic [7:0]  NEWLINE  = 8'h0A;
  localparam logic [5:0]  LEN_MAX  = 6'd63;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state;
  logic [1:0]  sync_q;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  assign rx_s = sync_q[1];
  assign busy = (state != IDLE);

  // Two-flop synchronizer for the asynchronous serial line, idling high.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], ser_rx};
    end
  end

  // Receive state machine: the counter counts down to 1 and the sample is
  // taken on that cycle, so a load of N samples exactly N cycles later.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      line_done <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      line_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= HALF_CNT;
          end
        end
        START: begin
          if (cnt == 16'd1) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= BIT_CNT;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DATA: begin
          if (cnt == 16'd1) begin
            shift <= {rx_s, shift[7:1]};
            cnt   <= BIT_CNT;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STOP: begin
          if (cnt == 16'd1) begin
            if (rx_s) begin
              rx_data   <= shift;
              rx_valid  <= 1'b1;
              line_done <= (shift == NEWLINE);
              state     <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Line length follows each committed byte one cycle after rx_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      line_len <= 6'd0;
    end else if (rx_valid) begin
      if (line_done) begin
        line_len <= 6'd0;
      end else if (line_len != LEN_MAX) begin
        line_len <= line_len + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_tb_uart.sv
// Self-checking bench for tb_uart: directed serial frames are driven on the
// falling clock edge, expected receive events go into a scoreboard queue and
// a monitor pops and compares them when the receiver pulses an output.
module tb_tb_uart;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       ser_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
  logic [5:0] line_len;
  logic       line_done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   exp_len = 0;
  logic [7:0] last_good = 8'h00;
  logic len_pending = 1'b0;

  tb_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock),
    .reset(reset),
    .ser_rx(ser_rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .busy(busy),
    .line_len(line_len),
    .line_done(line_done)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives one frame; stop_ok=0 holds the stop bit low for stop_bits bit times.
  task automatic send_byte(input logic [7:0] d, input logic stop_ok, input int stop_bits);
    exp_t e;
    e.is_err = ~stop_ok;
    e.data   = d;
    sb.push_back(e);
    ser_rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      ser_rx = d[i];
      wait_cyc(CPB);
    end
    ser_rx = stop_ok;
    wait_cyc(CPB * stop_bits);
    ser_rx = 1'b1;
  endtask

  // Monitor: pops the scoreboard on each output pulse and tracks line length.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      exp_len     = 0;
      last_good   = 8'h00;
      len_pending = 1'b0;
    end else begin
      if (len_pending) begin
        check("line_len", {26'd0, line_len}, exp_len);
        len_pending = 1'b0;
      end
      if (rx_valid || frame_err) begin
        check("valid_err_overlap", {31'd0, rx_valid & frame_err}, 0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", {31'd0, rx_valid | frame_err}, 0);
        end else begin
          e = sb.pop_front();
          if (!e.is_err) begin
            check("rx_valid", {31'd0, rx_valid}, 1);
            check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            check("line_done", {31'd0, line_done}, {31'd0, e.data == 8'h0A});
            last_good = e.data;
            if (e.data == 8'h0A) exp_len = 0;
            else if (exp_len < 63) exp_len = exp_len + 1;
            len_pending = 1'b1;
          end else begin
            check("frame_err", {31'd0, frame_err}, 1);
            check("rx_data_hold", {24'd0, rx_data}, {24'd0, last_good});
          end
        end
      end else if (line_done) begin
        check("stray_line_done", {31'd0, line_done}, 0);
      end
    end
  end

  // Directed test sequence.
  initial begin
    int n;
    logic [7:0] abort_byte;
    reset  = 1'b1;
    ser_rx = 1'b1;
    wait_cyc(3);
    check("reset_rx_data", {24'd0, rx_data}, 0);
    check("reset_rx_valid", {31'd0, rx_valid}, 0);
    check("reset_frame_err", {31'd0, frame_err}, 0);
    check("reset_line_len", {26'd0, line_len}, 0);
    check("reset_line_done", {31'd0, line_done}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    wait_cyc(2 * CPB);

    $display("[TB] single byte 0x41");
    send_byte(8'h41, 1'b1, 1);
    wait_cyc(CPB);
    check("len_after_41", {26'd0, line_len}, 1);

    $display("[TB] back-to-back A, B, newline");
    send_byte(8'h41, 1'b1, 1);
    send_byte(8'h42, 1'b1, 1);
    send_byte(8'h0A, 1'b1, 1);
    wait_cyc(CPB);
    check("len_after_newline", {26'd0, line_len}, 0);

    $display("[TB] 3-cycle glitch");
    ser_rx = 1'b0;
    wait_cyc(3);
    ser_rx = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      wait_cyc(1);
      n++;
    end
    check("glitch_busy_rise", {31'd0, busy}, 1);
    n = 0;
    while (busy && n < 40) begin
      wait_cyc(1);
      n++;
    end
    check("glitch_busy_fall", {31'd0, (busy == 1'b0) && (n <= HALF + 1)}, 1);
    wait_cyc(2 * CPB);
    check("glitch_no_event", sb.size(), 0);

    $display("[TB] framing error then 0x33");
    send_byte(8'h55, 1'b0, 2);
    wait_cyc(CPB);
    send_byte(8'h33, 1'b1, 1);
    wait_cyc(CPB);
    check("after_ferr_data", {24'd0, rx_data}, 8'h33);

    $display("[TB] reset during bit 4");
    abort_byte = 8'hA5;
    ser_rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      ser_rx = abort_byte[i];
      wait_cyc(CPB);
    end
    ser_rx = abort_byte[4];
    wait_cyc(HALF);
    check("busy_mid_frame", {31'd0, busy}, 1);
    reset  = 1'b1;
    ser_rx = 1'b1;
    wait_cyc(2);
    check("abort_rx_data", {24'd0, rx_data}, 0);
    check("abort_rx_valid", {31'd0, rx_valid}, 0);
    check("abort_frame_err", {31'd0, frame_err}, 0);
    check("abort_line_len", {26'd0, line_len}, 0);
    check("abort_line_done", {31'd0, line_done}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    wait_cyc(2 * CPB);
    send_byte(8'hA5, 1'b1, 1);
    wait_cyc(CPB);
    check("after_reset_data", {24'd0, rx_data}, 8'hA5);

    $display("[TB] 70 bytes then newline");
    for (int i = 0; i < 70; i++) begin
      send_byte(8'h30 + 8'(i % 10), 1'b1, 1);
    end
    wait_cyc(CPB);
    check("len_saturated", {26'd0, line_len}, 63);
    send_byte(8'h0A, 1'b1, 1);
    wait_cyc(CPB);
    check("len_cleared", {26'd0, line_len}, 0);

    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      wait_cyc(1);
      n++;
    end
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
